// File: rtl/proj_fm_index_sequencer_if.sv
// Handshake and configuration bundle between an FM read/write path controller
// and the index sequencer.
interface proj_fm_index_sequencer_if #(
  parameter int IDX_W  = 8,
  parameter int STEP_W = 4
);
  logic              in_start;
  logic              in_stop;
  logic              cfg_mode;
  logic [IDX_W-1:0]  cfg_base;
  logic [IDX_W-1:0]  cfg_limit;
  logic [STEP_W-1:0] cfg_step;
  logic              in_ready;
  logic [IDX_W-1:0]  out_index;
  logic              out_valid;
  logic              out_wrap;
  logic              out_done;
  logic              out_busy;

  modport master (
    output in_start, in_stop, cfg_mode, cfg_base, cfg_limit, cfg_step, in_ready,
    input  out_index, out_valid, out_wrap, out_done, out_busy
  );

  modport slave (
    input  in_start, in_stop, cfg_mode, cfg_base, cfg_limit, cfg_step, in_ready,
    output out_index, out_valid, out_wrap, out_done, out_busy
  );
endinterface

// File: rtl/proj_fm_index_sequencer.sv
// FM buffer index sequencer: walks base..limit by a programmable stride, in
// wrap or one-shot mode, advancing only on an accepted valid/ready beat.
module proj_fm_index_sequencer #(
  parameter int IDX_W  = 8,
  parameter int STEP_W = 4
) (
  input  logic                        in_clk,
  input  logic                        in_rst,
  proj_fm_index_sequencer_if.slave    bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [IDX_W-1:0]  base_q, base_d;
  logic [IDX_W-1:0]  limit_q, limit_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic              wrap_q, wrap_d;
  logic              done_q, done_d;

  logic [IDX_W:0]    nxtIdx;
  logic              beat;

  // One extra bit on the sum keeps a full-range walk from aliasing back below limit.
  assign nxtIdx = {1'b0, index_q} + (IDX_W+1)'(step_q);
  assign beat   = (state_q == ST_RUN) && bus.in_ready;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    base_d  = base_q;
    limit_d = limit_q;
    step_d  = step_q;
    index_d = index_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_start) begin
          state_d = ST_RUN;
          mode_d  = bus.cfg_mode;
          base_d  = bus.cfg_base;
          limit_d = (bus.cfg_base > bus.cfg_limit) ? bus.cfg_base : bus.cfg_limit;
          step_d  = (bus.cfg_step == '0) ? STEP_W'(1) : bus.cfg_step;
          index_d = bus.cfg_base;
        end
      end
      ST_RUN: begin
        if (bus.in_stop) begin
          state_d = ST_IDLE;
        end else if (beat) begin
          if (nxtIdx <= {1'b0, limit_q}) begin
            index_d = nxtIdx[IDX_W-1:0];
          end else if (!mode_q) begin
            index_d = base_q;
            wrap_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
      base_q  <= '0;
      limit_q <= '0;
      step_q  <= '0;
      index_q <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      base_q  <= base_d;
      limit_q <= limit_d;
      step_q  <= step_d;
      index_q <= index_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign bus.out_index = index_q;
  assign bus.out_valid = (state_q == ST_RUN);
  assign bus.out_busy  = (state_q == ST_RUN);
  assign bus.out_wrap  = wrap_q;
  assign bus.out_done  = done_q;

endmodule

// File: tb/tb_proj_fm_index_sequencer.sv
// Directed bench for proj_fm_index_sequencer: a behavioural model pushes the
// expected outputs of every cycle into a scoreboard that is popped after the edge.
module tb_proj_fm_index_sequencer;

  localparam int IDX_W  = 8;
  localparam int STEP_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  proj_fm_index_sequencer_if #(.IDX_W(IDX_W), .STEP_W(STEP_W)) bus ();

  proj_fm_index_sequencer #(.IDX_W(IDX_W), .STEP_W(STEP_W)) dut (
    .in_clk (clk),
    .in_rst (rst),
    .bus    (bus)
  );

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             valid;
    logic             wrap;
    logic             done;
    logic             busy;
  } obs_t;

  obs_t expQ[$];
  int   seenQ[$];
  int   total = 0;
  int   bad = 0;
  int   wrapCnt = 0;
  int   doneCnt = 0;

  int cMode, cBase, cLimit, cStep;
  int mRun, mIdx, mBase, mLimit, mStep, mMode;

  task automatic checkConst(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic setCfg(input int mode, input int base, input int limit, input int step);
    cMode = mode; cBase = base; cLimit = limit; cStep = step;
    bus.cfg_mode  = mode[0];
    bus.cfg_base  = base[IDX_W-1:0];
    bus.cfg_limit = limit[IDX_W-1:0];
    bus.cfg_step  = step[STEP_W-1:0];
  endtask

  // Reference behaviour: predicts the outputs visible after the coming edge.
  task automatic modelStep(input bit start, input bit stop, input bit ready);
    obs_t e;
    int   n;
    e = '0;
    if (mRun == 0) begin
      if (start) begin
        mMode  = cMode;
        mBase  = cBase;
        mLimit = (cBase > cLimit) ? cBase : cLimit;
        mStep  = (cStep == 0) ? 1 : cStep;
        mIdx   = cBase;
        mRun   = 1;
      end
    end else if (stop) begin
      mRun = 0;
    end else if (ready) begin
      n = mIdx + mStep;
      if (n <= mLimit) begin
        mIdx = n;
      end else if (mMode == 0) begin
        mIdx   = mBase;
        e.wrap = 1'b1;
      end else begin
        mRun   = 0;
        e.done = 1'b1;
      end
    end
    e.idx   = mIdx[IDX_W-1:0];
    e.valid = (mRun != 0);
    e.busy  = (mRun != 0);
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string tag);
    obs_t o, e;
    o = {bus.out_index, bus.out_valid, bus.out_wrap, bus.out_done, bus.out_busy};
    total++;
    if (expQ.size() == 0) begin
      bad++;
      $error("FAIL %s: scoreboard empty, got idx=%0d", tag, o.idx);
    end else begin
      e = expQ.pop_front();
      assert (o === e) else begin
        bad++;
        $error("FAIL %s: got idx=%0d v=%b w=%b d=%b b=%b, want idx=%0d v=%b w=%b d=%b b=%b",
               tag, o.idx, o.valid, o.wrap, o.done, o.busy,
               e.idx, e.valid, e.wrap, e.done, e.busy);
      end
    end
  endtask

  task automatic applyStimulus(input bit start, input bit stop, input bit ready, input string tag);
    bus.in_start = start;
    bus.in_stop  = stop;
    bus.in_ready = ready;
    if (bus.out_valid && ready && !stop) seenQ.push_back(int'(bus.out_index));
    modelStep(start, stop, ready);
    @(posedge clk);
    #1;
    bus.in_start = 1'b0;
    bus.in_stop  = 1'b0;
    checkOutput(tag);
    if (bus.out_wrap) wrapCnt++;
    if (bus.out_done) doneCnt++;
  endtask

  task automatic clearTally();
    seenQ.delete();
    wrapCnt = 0;
    doneCnt = 0;
  endtask

  initial begin
    int wrapSeq[9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
    int osSeq[3]   = '{2, 5, 8};

    mRun = 0; mIdx = 0; mBase = 0; mLimit = 0; mStep = 0; mMode = 0;
    rst = 1'b1;
    bus.in_start = 1'b0;
    bus.in_stop  = 1'b0;
    bus.in_ready = 1'b0;
    setCfg(0, 0, 0, 0);
    #12;
    expQ.push_back('0);
    checkOutput("reset");
    rst = 1'b0;

    // Wrap mode 0..3 step 1
    clearTally();
    setCfg(0, 0, 3, 1);
    applyStimulus(1, 0, 1, "wrap_start");
    repeat (9) applyStimulus(0, 0, 1, "wrap_run");
    for (int i = 0; i < 9; i++) checkConst("wrap_seq", (i < seenQ.size()) ? seenQ[i] : -1, wrapSeq[i]);
    checkConst("wrap_pulses", wrapCnt, 2);

    // Backpressure in the same run
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 0, 1, "bp_go");
      applyStimulus(0, 0, 0, "bp_hold");
      applyStimulus(0, 0, 0, "bp_hold");
      applyStimulus(0, 0, 1, "bp_go");
    end

    // Stop with ready high: no transfer, no pulses
    clearTally();
    applyStimulus(0, 1, 1, "stop_ready");
    applyStimulus(0, 0, 1, "idle_hold");
    checkConst("stop_no_wrap", wrapCnt, 0);
    checkConst("stop_no_done", doneCnt, 0);

    // One-shot with stride 3 and a stall after the first valid
    clearTally();
    setCfg(1, 2, 9, 3);
    applyStimulus(1, 0, 0, "os_start");
    applyStimulus(0, 0, 0, "os_stall");
    repeat (4) applyStimulus(0, 0, 1, "os_run");
    checkConst("os_beats", seenQ.size(), 3);
    for (int i = 0; i < 3; i++) checkConst("os_seq", (i < seenQ.size()) ? seenQ[i] : -1, osSeq[i]);
    checkConst("os_done", doneCnt, 1);

    // Start and cfg changes during RUN are ignored
    setCfg(0, 10, 20, 2);
    applyStimulus(1, 0, 1, "run_start");
    setCfg(0, 50, 60, 5);
    applyStimulus(1, 0, 1, "run_restart_ignored");
    applyStimulus(0, 0, 1, "run_cfg_ignored");
    checkConst("run_idx", int'(bus.out_index), 14);
    applyStimulus(0, 1, 0, "run_stop");

    // base > limit one-shot, start+stop together in IDLE
    clearTally();
    setCfg(1, 200, 100, 5);
    applyStimulus(1, 1, 0, "edge_start_stop");
    checkConst("edge_first", int'(bus.out_index), 200);
    applyStimulus(0, 0, 1, "edge_last");
    checkConst("edge_done", doneCnt, 1);

    // Stride 0 behaves as 1
    clearTally();
    setCfg(0, 5, 7, 0);
    applyStimulus(1, 0, 1, "step0_start");
    repeat (4) applyStimulus(0, 0, 1, "step0_run");
    checkConst("step0_idx", int'(bus.out_index), 6);
    checkConst("step0_wrap", wrapCnt, 1);
    applyStimulus(0, 1, 1, "step0_stop");

    // Full-range wrap 0..255
    clearTally();
    setCfg(0, 0, 255, 1);
    applyStimulus(1, 0, 1, "full_start");
    repeat (257) applyStimulus(0, 0, 1, "full_run");
    checkConst("full_wrap", wrapCnt, 1);
    checkConst("full_last", (seenQ.size() > 255) ? seenQ[255] : -1, 255);
    checkConst("full_after", (seenQ.size() > 256) ? seenQ[256] : -1, 0);
    applyStimulus(0, 1, 0, "full_stop");

    // Async reset mid-run, then a fresh start
    setCfg(0, 30, 40, 2);
    applyStimulus(1, 0, 1, "ar_start");
    applyStimulus(0, 0, 1, "ar_run");
    applyStimulus(0, 0, 1, "ar_run");
    #2;
    rst = 1'b1;
    #1;
    mRun = 0; mIdx = 0; mBase = 0; mLimit = 0; mStep = 0; mMode = 0;
    expQ.push_back('0);
    checkOutput("async_rst");
    #1;
    rst = 1'b0;
    clearTally();
    setCfg(1, 7, 8, 1);
    applyStimulus(1, 0, 1, "ar_restart");
    repeat (3) applyStimulus(0, 0, 1, "ar_rerun");
    checkConst("ar_beats", seenQ.size(), 2);
    checkConst("ar_first", (seenQ.size() > 0) ? seenQ[0] : -1, 7);
    checkConst("ar_done", doneCnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
